// File: rtl/apb_timer_regs.sv
// apb_timer_regs
// ---------------------------------------------------------------------------
// APB completer holding the timer register file, the 64-bit up-counter, its
// prescaler and the compare interrupt.
//
// Ports
//   pclk, preset        clock (rising edge) and asynchronous active-high reset
//   psel, penable,      APB request: select, access-phase flag, direction,
//   pwrite, paddr,      byte address (only [ADDR_W-1:0] decoded, word aligned)
//   pwdata              and write data
//   prdata              read data, nonzero only while pready is high on a read
//   pready              transfer completion
//   pslverr             unmapped-offset error, only while pready is high
//   tim_int             level interrupt, registered TISR[0] & TIER[0]
//   dbg_state_o         bus FSM state, for observation only
//
// Build option
//   APB_WAIT_STATE_EN   when defined, every transfer has one wait cycle and
//                       read data is sampled at the end of that wait cycle.
//
// Handshake: a transfer is a setup cycle (psel & !penable) followed by access
// cycles (psel & penable). The transfer completes, and a write commits, in the
// access cycle where pready is high. Inputs must be held stable until then.
// ---------------------------------------------------------------------------
module apb_timer_regs #(
    parameter int ADDR_W = 12
) (
    input  logic        pclk,
    input  logic        preset,
    input  logic        psel,
    input  logic        penable,
    input  logic        pwrite,
    input  logic [31:0] paddr,
    input  logic [31:0] pwdata,
    output logic [31:0] prdata,
    output logic        pready,
    output logic        pslverr,
    output logic        tim_int,
    output logic [1:0]  dbg_state_o
);

    // state_q names the bus phase completed in the previous cycle:
    // ST_SETUP  -> the current cycle is the first access cycle,
    // ST_ACCESS -> the wait cycle is over (only reachable with a wait state).
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic        timer_en_q, timer_en_d;
    logic        div_en_q,   div_en_d;
    logic [3:0]  div_val_q,  div_val_d;
    logic [63:0] cnt_q,      cnt_d;
    logic [63:0] cmp_q,      cmp_d;
    logic        int_en_q,   int_en_d;
    logic        int_st_q,   int_st_d;
    logic        tim_int_q;
    logic [7:0]  psc_q,      psc_d;

    logic [ADDR_W-1:0] off;
    logic sel_tcr, sel_tdr0, sel_tdr1, sel_cmp0, sel_cmp1, sel_tier, sel_tisr;
    logic addr_hit;
    logic [31:0] rd_mux;
    logic wr_en;
    logic tick, match;
    logic [3:0] div_eff;
    logic [7:0] psc_lim;

    // Upper address bits are intentionally ignored.
    logic unused_paddr;
    assign unused_paddr = ^paddr[31:ADDR_W];

    assign off = paddr[ADDR_W-1:0];

    // ---------------- address decode and read mux ----------------
    always_comb begin
        sel_tcr  = (off == ADDR_W'('h000));
        sel_tdr0 = (off == ADDR_W'('h004));
        sel_tdr1 = (off == ADDR_W'('h008));
        sel_cmp0 = (off == ADDR_W'('h00C));
        sel_cmp1 = (off == ADDR_W'('h010));
        sel_tier = (off == ADDR_W'('h014));
        sel_tisr = (off == ADDR_W'('h018));
        addr_hit = sel_tcr | sel_tdr0 | sel_tdr1 | sel_cmp0 | sel_cmp1 | sel_tier | sel_tisr;
        rd_mux   = '0;
        if (sel_tcr)  rd_mux = {20'd0, div_val_q, 6'd0, div_en_q, timer_en_q};
        if (sel_tdr0) rd_mux = cnt_q[31:0];
        if (sel_tdr1) rd_mux = cnt_q[63:32];
        if (sel_cmp0) rd_mux = cmp_q[31:0];
        if (sel_cmp1) rd_mux = cmp_q[63:32];
        if (sel_tier) rd_mux = {31'd0, int_en_q};
        if (sel_tisr) rd_mux = {31'd0, int_st_q};
    end

    // ---------------- bus FSM next state ----------------
    always_comb begin
        state_d = state_q;
        if (!psel) begin
            state_d = ST_IDLE;
        end else if (!penable) begin
            state_d = ST_SETUP;
        end else begin
            case (state_q)
`ifdef APB_WAIT_STATE_EN
                ST_SETUP:  state_d = ST_ACCESS;
`else
                ST_SETUP:  state_d = ST_IDLE;
`endif
                ST_ACCESS: state_d = ST_IDLE;
                default:   state_d = ST_IDLE;
            endcase
        end
    end

`ifdef APB_WAIT_STATE_EN
    logic [31:0] rdata_q;

    assign pready = psel & penable & (state_q == ST_ACCESS);
    assign prdata = (pready & ~pwrite) ? rdata_q : 32'd0;

    // Read data is captured at the end of the wait cycle.
    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            rdata_q <= '0;
        end else if (psel && penable && state_q == ST_SETUP) begin
            rdata_q <= rd_mux;
        end
    end
`else
    assign pready = psel & penable & (state_q == ST_SETUP);
    assign prdata = (pready & ~pwrite) ? rd_mux : 32'd0;
`endif

    assign pslverr     = pready & ~addr_hit;
    assign wr_en       = psel & penable & pwrite & pready;
    assign tim_int     = tim_int_q;
    assign dbg_state_o = state_q;

    // ---------------- register, prescaler, counter next state ----------------
    always_comb begin
        timer_en_d = timer_en_q;
        div_en_d   = div_en_q;
        div_val_d  = div_val_q;
        cmp_d      = cmp_q;
        int_en_d   = int_en_q;

        if (wr_en && sel_tcr) begin
            timer_en_d = pwdata[0];
            div_en_d   = pwdata[1];
            div_val_d  = pwdata[11:8];
        end
        if (wr_en && sel_cmp0) cmp_d[31:0]  = pwdata;
        if (wr_en && sel_cmp1) cmp_d[63:32] = pwdata;
        if (wr_en && sel_tier) int_en_d     = pwdata[0];

        // Prescaler counts 0 .. 2^div_val-1; divisors above 256 saturate.
        div_eff = (div_val_q > 4'd8) ? 4'd8 : div_val_q;
        psc_lim = 8'((9'd1 << div_eff) - 9'd1);
        tick    = !div_en_q || (psc_q == psc_lim);

        if (!timer_en_q || !div_en_q || (wr_en && sel_tcr) || tick) begin
            psc_d = '0;
        end else begin
            psc_d = psc_q + 8'd1;
        end

        // A TDR write overrides the increment; the other half keeps its old value.
        cnt_d = cnt_q;
        if (timer_en_q && tick) cnt_d = cnt_q + 64'd1;
        if (wr_en && sel_tdr0)  cnt_d = {cnt_q[63:32], pwdata};
        if (wr_en && sel_tdr1)  cnt_d = {pwdata, cnt_q[31:0]};

        // Set beats a same-cycle write-1-to-clear.
        match    = (cnt_q == cmp_q);
        int_st_d = int_st_q;
        if (wr_en && sel_tisr && pwdata[0]) int_st_d = 1'b0;
        if (match)                          int_st_d = 1'b1;
    end

    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            state_q    <= ST_IDLE;
            timer_en_q <= 1'b0;
            div_en_q   <= 1'b0;
            div_val_q  <= 4'd1;
            cnt_q      <= '0;
            cmp_q      <= '1;
            int_en_q   <= 1'b0;
            int_st_q   <= 1'b0;
            tim_int_q  <= 1'b0;
            psc_q      <= '0;
        end else begin
            state_q    <= state_d;
            timer_en_q <= timer_en_d;
            div_en_q   <= div_en_d;
            div_val_q  <= div_val_d;
            cnt_q      <= cnt_d;
            cmp_q      <= cmp_d;
            int_en_q   <= int_en_d;
            int_st_q   <= int_st_d;
            tim_int_q  <= int_st_d & int_en_d;
            psc_q      <= psc_d;
        end
    end

endmodule

// File: tb/tb_apb_timer_regs.sv
module tb_apb_timer_regs;

`ifdef APB_WAIT_STATE_EN
    localparam int WS = 1;
`else
    localparam int WS = 0;
`endif

    logic        pclk;
    logic        preset;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] paddr;
    logic [31:0] pwdata;
    logic [31:0] prdata;
    logic        pready;
    logic        pslverr;
    logic        tim_int;
    logic [1:0]  dbg_state;

    int n_cmp  = 0;
    int n_fail = 0;

    apb_timer_regs #(.ADDR_W(12)) dut (
        .pclk        (pclk),
        .preset      (preset),
        .psel        (psel),
        .penable     (penable),
        .pwrite      (pwrite),
        .paddr       (paddr),
        .pwdata      (pwdata),
        .prdata      (prdata),
        .pready      (pready),
        .pslverr     (pslverr),
        .tim_int     (tim_int),
        .dbg_state_o (dbg_state)
    );

    // ---------------- clock ----------------
    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    // ---------------- checking ----------------
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // ---------------- driver ----------------
    // One APB transfer; inputs change 1ns after a rising edge and outputs are
    // sampled 4ns after it. Each transfer is followed by one idle cycle.
    task automatic apb(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                       output logic [31:0] rd, output logic err);
        int  waits;
        bit  done;
        @(posedge pclk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = wdata;
        @(posedge pclk); #1;
        penable = 1'b1;
        waits = 0;
        done  = 1'b0;
        rd    = '0;
        err   = 1'b0;
        while (!done) begin
            #3;
            if (pready === 1'b1) begin
                rd   = prdata;
                err  = pslverr;
                done = 1'b1;
            end else begin
                waits++;
                if (waits > 8) done = 1'b1;
                else begin
                    @(posedge pclk); #1;
                end
            end
        end
        chk("wait_cycles", 64'(waits), 64'(WS));
        @(posedge pclk); #1;
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    endtask

    task automatic do_wr(input logic [31:0] addr, input logic [31:0] data, input logic exp_err);
        logic [31:0] d;
        logic        e;
        apb(1'b1, addr, data, d, e);
        chk("wr_pslverr", 64'(e), 64'(exp_err));
    endtask

    task automatic do_rd(input logic [31:0] addr, input logic [31:0] exp, input logic exp_err,
                         input string tag);
        logic [31:0] d;
        logic        e;
        apb(1'b0, addr, 32'd0, d, e);
        chk(tag, 64'(d), 64'(exp));
        chk({tag, "_pslverr"}, 64'(e), 64'(exp_err));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [31:0] reset_vals [7];
        reset_vals = '{32'h0000_0100, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0};

        preset = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        paddr = '0; pwdata = '0;

        // Outputs in reset
        #2;
        chk("rst_pready",  64'(pready),    64'd0);
        chk("rst_prdata",  64'(prdata),    64'd0);
        chk("rst_pslverr", 64'(pslverr),   64'd0);
        chk("rst_tim_int", 64'(tim_int),   64'd0);
        chk("rst_state",   64'(dbg_state), 64'd0);
        repeat (3) @(posedge pclk);
        #1 preset = 1'b0;

        // Reset values of all registers
        for (int i = 0; i < 7; i++) begin
            do_rd(32'(i * 4), reset_vals[i], 1'b0, $sformatf("reset_reg%0d", i));
        end

        // Write/read-back, unmapped offset, upper address bits ignored
        do_wr(32'h00C, 32'h0000_55AA, 1'b0);
        do_rd(32'h00C, 32'h0000_55AA, 1'b0, "tcmp0_rb");
        do_wr(32'h01C, 32'hDEAD_BEEF, 1'b1);
        do_rd(32'h01C, 32'd0,         1'b1, "unmapped_rd");
        do_rd(32'h00C, 32'h0000_55AA, 1'b0, "tcmp0_keep");
        do_rd(32'h010, 32'hFFFF_FFFF, 1'b0, "tcmp1_keep");
        do_rd(32'h000, 32'h0000_0100, 1'b0, "tcr_keep");
        do_rd(32'h1000_000C, 32'h0000_55AA, 1'b0, "upper_addr_ignored");

        // Compare interrupt: counter starts at 0 when TCR commits at edge E0,
        // reaches 10 at E10, tim_int rises at E11.
        do_wr(32'h00C, 32'd10, 1'b0);
        do_wr(32'h010, 32'd0,  1'b0);
        do_wr(32'h014, 32'd1,  1'b0);
        chk("int_before_run", 64'(tim_int), 64'd0);
        do_wr(32'h000, 32'd1,  1'b0);
        repeat (10) @(posedge pclk);
        #1 chk("int_at_e10", 64'(tim_int), 64'd0);
        @(posedge pclk);
        #1 chk("int_at_e11", 64'(tim_int), 64'd1);
        repeat (5) @(posedge pclk);
        #1 chk("int_level_hold", 64'(tim_int), 64'd1);
        do_rd(32'h018, 32'd1, 1'b0, "tisr_set");
        do_wr(32'h018, 32'd1, 1'b0);
        chk("int_after_w1c", 64'(tim_int), 64'd0);
        do_rd(32'h018, 32'd0, 1'b0, "tisr_cleared");
        do_wr(32'h000, 32'd0, 1'b0);

        // TCR reserved bits read 0
        do_wr(32'h000, 32'hFFFF_FFFE, 1'b0);
        do_rd(32'h000, 32'h0000_0F02, 1'b0, "tcr_mask");

        // Divide by 4: counter = floor(k/4) at edge E_k after the TCR commit.
        // Read i samples the counter at edge 41 + i*(3+WS).
        do_wr(32'h000, 32'd0, 1'b0);
        do_wr(32'h004, 32'd0, 1'b0);
        do_wr(32'h008, 32'd0, 1'b0);
        do_wr(32'h000, 32'h0000_0203, 1'b0);
        repeat (39) @(posedge pclk);
        #1;
        for (int i = 0; i < 4; i++) begin
            do_rd(32'h004, 32'((41 + i * (3 + WS)) / 4), 1'b0, $sformatf("div4_rd%0d", i));
        end
        do_wr(32'h000, 32'd0, 1'b0);

        // 64-bit wrap, then a TDR0 write on a tick cycle takes no +1
        do_wr(32'h004, 32'hFFFF_FFFF, 1'b0);
        do_wr(32'h008, 32'hFFFF_FFFF, 1'b0);
        do_wr(32'h000, 32'd1, 1'b0);
        do_rd(32'h004, 32'd1, 1'b0, "wrap_tdr0");
        do_rd(32'h008, 32'd0, 1'b0, "wrap_tdr1");
        do_wr(32'h004, 32'h0000_1000, 1'b0);
        do_rd(32'h004, 32'h0000_1002, 1'b0, "tdr0_write_wins");
        do_rd(32'h008, 32'd0, 1'b0, "tdr1_holds");
        do_wr(32'h000, 32'd0, 1'b0);

        // Reset asserted in the first access cycle aborts the write
        @(posedge pclk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h00C; pwdata = 32'h0000_1234;
        @(posedge pclk); #1;
        penable = 1'b1;
        #1 preset = 1'b1;
        #1 chk("abort_pready", 64'(pready), 64'd0);
        chk("abort_state", 64'(dbg_state), 64'd0);
        @(posedge pclk); #1;
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        @(posedge pclk); #1;
        preset = 1'b0;
        do_rd(32'h00C, 32'hFFFF_FFFF, 1'b0, "abort_no_write");
        do_rd(32'h000, 32'h0000_0100, 1'b0, "abort_tcr_reset");
        do_rd(32'h004, 32'd0,         1'b0, "abort_tdr0_reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
